// File: rtl/push_pop_button_conditioner.sv
// Push/pop button front end for the occupancy counter.
// Each raw button is synchronised and debounced, then fed to a repeat FSM
// (press pulse, optional auto-repeat). The output stage turns the two event
// streams into mutually exclusive single-cycle push/pop commands and flags a
// conflict when both events land in the same cycle.
module push_pop_button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned REPEAT_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_push_raw,
  input  logic btn_pop_raw,
  output logic push,
  output logic pop,
  output logic conflict,
  output logic push_level,
  output logic pop_level
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned TM_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TM_W   = $clog2(TM_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  // Channel 0 is push, channel 1 is pop.
  logic [1:0] raw_s;
  logic [1:0] event_s;
  logic [1:0] level_s;

  logic push_r;
  logic pop_r;
  logic conflict_r;

  assign raw_s = {btn_pop_raw, btn_push_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic            q1_r;
    logic            q2_r;
    logic            level_r;
    logic [DB_W-1:0] db_cnt_r;
    state_t          state_r;
    state_t          state_nxt_s;
    logic [TM_W-1:0] timer_r;
    logic [TM_W-1:0] timer_nxt_s;
    logic            ev_s;

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge clk) begin
      if (reset) begin
        q1_r <= 1'b0;
        q2_r <= 1'b0;
      end else begin
        q1_r <= raw_s[ch];
        q2_r <= q1_r;
      end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
      if (reset) begin
        db_cnt_r <= {DB_W{1'b0}};
        level_r  <= 1'b0;
      end else if (q2_r != level_r) begin
        if (db_cnt_r == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_r  <= ~level_r;
          db_cnt_r <= {DB_W{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + DB_W'(1);
        end
      end else begin
        db_cnt_r <= {DB_W{1'b0}};
      end
    end

    // Repeat FSM state and timer registers.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_r <= ST_IDLE;
        timer_r <= {TM_W{1'b0}};
      end else begin
        state_r <= state_nxt_s;
        timer_r <= timer_nxt_s;
      end
    end

    // Repeat FSM next state: press event on level rise, timed repeat events while held.
    always_comb begin
      state_nxt_s = state_r;
      timer_nxt_s = timer_r;
      ev_s        = 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (level_r) begin
            state_nxt_s = ST_HOLD;
            timer_nxt_s = TM_W'(HOLD_CYCLES);
            ev_s        = 1'b1;
          end else begin
            timer_nxt_s = {TM_W{1'b0}};
          end
        end
        ST_HOLD: begin
          if (!level_r) begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = {TM_W{1'b0}};
          end else if (REPEAT_EN != 32'd0) begin
            if (timer_r == TM_W'(1)) begin
              state_nxt_s = ST_REPEAT;
              timer_nxt_s = TM_W'(REPEAT_CYCLES);
              ev_s        = 1'b1;
            end else begin
              timer_nxt_s = timer_r - TM_W'(1);
            end
          end else begin
            // Single pulse per press: park here until release.
            timer_nxt_s = timer_r;
          end
        end
        ST_REPEAT: begin
          if (!level_r) begin
            state_nxt_s = ST_IDLE;
            timer_nxt_s = {TM_W{1'b0}};
          end else if (timer_r == TM_W'(1)) begin
            timer_nxt_s = TM_W'(REPEAT_CYCLES);
            ev_s        = 1'b1;
          end else begin
            timer_nxt_s = timer_r - TM_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          timer_nxt_s = {TM_W{1'b0}};
        end
      endcase
    end

    assign event_s[ch] = ev_s;
    assign level_s[ch] = level_r;
  end

  // Output stage: exclusive push/pop pulses; coincident events are dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_r     <= 1'b0;
      pop_r      <= 1'b0;
      conflict_r <= 1'b0;
    end else begin
      push_r     <= event_s[0] & ~event_s[1];
      pop_r      <= event_s[1] & ~event_s[0];
      conflict_r <= event_s[0] &  event_s[1];
    end
  end

  assign push       = push_r;
  assign pop        = pop_r;
  assign conflict   = conflict_r;
  assign push_level = level_s[0];
  assign pop_level  = level_s[1];

endmodule

// File: tb/tb_push_pop_button_conditioner.sv
// Directed bench: one instance with auto-repeat (D=4, HOLD=8, REPEAT=3) and
// one single-pulse instance (D=4, REPEAT_EN=0). Cycle index k counts rising
// edges after a stimulus change; raw changes are sampled at k=1, so a press
// shows push_level at k=6 and the press pulse at k=7.
module tb_push_pop_button_conditioner;

  logic clk;
  logic reset;

  logic rep_push_raw, rep_pop_raw;
  logic rep_push, rep_pop, rep_conflict, rep_push_level, rep_pop_level;
  logic one_push_raw, one_pop_raw;
  logic one_push, one_pop, one_conflict, one_push_level, one_pop_level;

  int checks;
  int errors;

  push_pop_button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
  ) dut_rep (
    .clk(clk), .reset(reset),
    .btn_push_raw(rep_push_raw), .btn_pop_raw(rep_pop_raw),
    .push(rep_push), .pop(rep_pop), .conflict(rep_conflict),
    .push_level(rep_push_level), .pop_level(rep_pop_level)
  );

  push_pop_button_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .HOLD_CYCLES(8), .REPEAT_CYCLES(3)
  ) dut_one (
    .clk(clk), .reset(reset),
    .btn_push_raw(one_push_raw), .btn_pop_raw(one_pop_raw),
    .push(one_push), .pop(one_pop), .conflict(one_conflict),
    .push_level(one_push_level), .pop_level(one_pop_level)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    rep_push_raw = 1'b0;
    rep_pop_raw  = 1'b0;
    one_push_raw = 1'b0;
    one_pop_raw  = 1'b0;
    for (int i = 0; i < 15; i++) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if ({rep_push, rep_pop, rep_conflict, rep_push_level, rep_pop_level} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_rep got %b exp 00000",
               {rep_push, rep_pop, rep_conflict, rep_push_level, rep_pop_level});
    end
    checks++;
    if ({one_push, one_pop, one_conflict, one_push_level, one_pop_level} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_one got %b exp 00000",
               {one_push, one_pop, one_conflict, one_push_level, one_pop_level});
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_clean_press();
    logic exp_push, exp_lvl;
    one_push_raw = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      exp_push = (k == 7);
      exp_lvl  = (k >= 6);
      checks++;
      if (one_push !== exp_push) begin
        errors++;
        $display("FAIL clean_push k=%0d got %b exp %b", k, one_push, exp_push);
      end
      checks++;
      if (one_push_level !== exp_lvl) begin
        errors++;
        $display("FAIL clean_level k=%0d got %b exp %b", k, one_push_level, exp_lvl);
      end
      checks++;
      if ({one_pop, one_conflict} !== 2'b00) begin
        errors++;
        $display("FAIL clean_quiet k=%0d got %b exp 00", k, {one_pop, one_conflict});
      end
      if (k == 30) one_push_raw = 1'b0;
    end
    settle();
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    logic exp_pop, exp_lvl;
    pat = 8'b11001100;
    for (int i = 0; i < 8; i++) begin
      one_pop_raw = pat[7-i];
      step();
      checks++;
      if ({one_pop, one_pop_level} !== 2'b00) begin
        errors++;
        $display("FAIL bounce_quiet i=%0d got %b exp 00", i, {one_pop, one_pop_level});
      end
    end
    one_pop_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_pop = (k == 7);
      exp_lvl = (k >= 6);
      checks++;
      if ({one_pop, one_pop_level, one_push} !== {exp_pop, exp_lvl, 1'b0}) begin
        errors++;
        $display("FAIL bounce_stable k=%0d got %b exp %b", k,
                 {one_pop, one_pop_level, one_push}, {exp_pop, exp_lvl, 1'b0});
      end
    end
    settle();
  endtask

  task automatic test_auto_repeat();
    logic exp_push, exp_lvl;
    rep_push_raw = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      // First pulse T=7, then T+8, T+11, T+14, T+17.
      exp_push = (k == 7) || (k == 15) || (k == 18) || (k == 21) || (k == 24);
      exp_lvl  = (k >= 6) && (k <= 25);
      checks++;
      if (rep_push !== exp_push) begin
        errors++;
        $display("FAIL repeat_push k=%0d got %b exp %b", k, rep_push, exp_push);
      end
      checks++;
      if (rep_push_level !== exp_lvl) begin
        errors++;
        $display("FAIL repeat_level k=%0d got %b exp %b", k, rep_push_level, exp_lvl);
      end
      checks++;
      if ({rep_pop, rep_conflict} !== 2'b00) begin
        errors++;
        $display("FAIL repeat_quiet k=%0d got %b exp 00", k, {rep_pop, rep_conflict});
      end
      if (k == 20) rep_push_raw = 1'b0;
    end
    settle();
  endtask

  task automatic test_simultaneous();
    logic exp_conf;
    one_push_raw = 1'b1;
    one_pop_raw  = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_conf = (k == 7);
      checks++;
      if ({one_push, one_pop, one_conflict} !== {2'b00, exp_conf}) begin
        errors++;
        $display("FAIL simul k=%0d got %b exp %b", k,
                 {one_push, one_pop, one_conflict}, {2'b00, exp_conf});
      end
    end
    settle();
  endtask

  task automatic test_reset_mid_hold();
    logic exp_push, exp_lvl;
    rep_push_raw = 1'b1;
    for (int k = 1; k <= 16; k++) step();
    checks++;
    if ({rep_push_level, rep_push} !== 2'b10) begin
      errors++;
      $display("FAIL midhold_pre got %b exp 10", {rep_push_level, rep_push});
    end
    reset = 1'b1;
    step();
    checks++;
    if ({rep_push, rep_pop, rep_conflict, rep_push_level, rep_pop_level} !== 5'b00000) begin
      errors++;
      $display("FAIL midhold_reset got %b exp 00000",
               {rep_push, rep_pop, rep_conflict, rep_push_level, rep_pop_level});
    end
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_push = (k == 7) || (k == 15);
      exp_lvl  = (k >= 6);
      checks++;
      if ({rep_push, rep_push_level} !== {exp_push, exp_lvl}) begin
        errors++;
        $display("FAIL midhold_after k=%0d got %b exp %b", k,
                 {rep_push, rep_push_level}, {exp_push, exp_lvl});
      end
    end
    settle();
  endtask

  task automatic test_short_release();
    logic exp_push, exp_lvl;
    rep_push_raw = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      step();
      exp_push = (k == 7) || (k == 15) || (k == 18) || (k == 21) || (k == 24);
      exp_lvl  = (k >= 6);
      checks++;
      if ({rep_push, rep_push_level} !== {exp_push, exp_lvl}) begin
        errors++;
        $display("FAIL short_release k=%0d got %b exp %b", k,
                 {rep_push, rep_push_level}, {exp_push, exp_lvl});
      end
      if (k == 9)  rep_push_raw = 1'b0;
      if (k == 12) rep_push_raw = 1'b1;
    end
    settle();
  endtask

  initial begin
    clk          = 1'b0;
    reset        = 1'b1;
    rep_push_raw = 1'b0;
    rep_pop_raw  = 1'b0;
    one_push_raw = 1'b0;
    one_pop_raw  = 1'b0;
    checks       = 0;
    errors       = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_simultaneous();
    test_reset_mid_hold();
    test_short_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/push_pop_button_conditioner.md
Name: push_pop_button_conditioner

Overview:
- Front-end conditioner for the push/pop up/down occupancy counter; sits directly upstream of it.
- Takes two raw, asynchronous, bouncing push-buttons and drives single-cycle, mutually exclusive push and pop command pulses in the clk domain.
- Optional auto-repeat while a button is held.
- Also exports the debounced button levels for LEDs/status.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a level change; must be >= 1.
- REPEAT_EN, 1, 1 enables auto-repeat while held; 0 gives one pulse per press.
- HOLD_CYCLES, 64, cycles from the initial press pulse to the first repeat pulse; must be >= 1.
- REPEAT_CYCLES, 16, cycles between subsequent repeat pulses; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  reset, synchronous, active-high.
- btn_push_raw  input  1  raw asynchronous push button, active-high.
- btn_pop_raw  input  1  raw asynchronous pop button, active-high.
- push  output  1  one-cycle increment command to the counter.
- pop  output  1  one-cycle decrement command to the counter.
- conflict  output  1  one-cycle flag: coincident push/pop events were suppressed.
- push_level  output  1  debounced push button level.
- pop_level  output  1  debounced pop button level.

Behaviour:
- Reset (reset=1 at a rising edge): all sync flops, debounced levels, counters and outputs go to 0. Reset has priority over every other condition. Asserting reset mid-press or mid-repeat aborts immediately.
- After reset release, a still-held button is re-qualified from scratch and produces a fresh press pulse.

Per channel (push and pop are identical and independent):
- Synchronizer: two-flop chain, q1 <= raw, q2 <= q1. Only q2 is used downstream.
- Debounce counter: width clog2(DEBOUNCE_CYCLES)+1.
  - At each edge where q2 != level, the counter increments.
  - When the counter has seen DEBOUNCE_CYCLES consecutive differing edges, level toggles and the counter clears.
  - Any edge with q2 == level clears the counter.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes level.
- Latency: raw held high from sampling edge N -> level rises at edge N+1+DEBOUNCE_CYCLES -> press event at edge N+2+DEBOUNCE_CYCLES. Release uses the same debounce timing and generates no event.
- Repeat FSM: IDLE, HOLD, REPEAT.
  - IDLE -> HOLD on the level rising edge: emit press event, load timer = HOLD_CYCLES.
  - HOLD: the timer decrements every cycle. At expiry, emit an event and go to REPEAT with timer = REPEAT_CYCLES.
  - REPEAT: at each expiry, emit an event and reload REPEAT_CYCLES.
  - Level falling in any state -> IDLE, timer cleared, no event.
  - With REPEAT_EN=0, HOLD stays in HOLD with no timer events until release.

Output stage (registered):
- If exactly one channel has an event in a cycle, the matching push or pop is 1 for exactly one cycle.
- If both channels have events in the same cycle, push=0, pop=0 and conflict=1 for one cycle. Neither event is retried; the FSM timers continue normally.
- push and pop are never high in the same cycle, so the counter never has to resolve simultaneity.
- push_level and pop_level are the debounced levels directly, with no extra delay.

Test Plan:
- Clean press: D=4, btn_push_raw 0->1 sampled at edge 10, held 30 cycles, REPEAT_EN=0 -> push=1 only in the cycle after edge 16; push_level=1 from edge 15; no further pulses; pop and conflict stay 0.
- Bounce rejection: D=4, btn_pop_raw toggles 1,0,1,0 every 2 cycles, then holds 1 -> no pop during bouncing; exactly one pop pulse, 6 cycles after the first edge of the stable-high run.
- Auto-repeat: D=4, HOLD=8, REPEAT=3, push held for 20 cycles after its first pulse at cycle T -> push pulses at T, T+8, T+11, T+14, T+17; none after release.
- Simultaneous: both raw inputs rise at the same edge, REPEAT_EN=0 -> conflict=1 for one cycle at edge N+6; push=pop=0 throughout.
- Reset mid-hold: push held in REPEAT state, reset pulsed 1 cycle while the button stays held -> all outputs 0 at the reset edge; a new push pulse arrives D+2 cycles after release and the HOLD timing restarts.
- Short release: push held, raw drops for 3 cycles (D=4), then returns -> push_level stays 1; no new press pulse; repeat cadence is undisturbed.
